data_mem_responder: RTL and testbench

//  Responder side of the CPU data-memory port: services m_data_addr/wdata/byteen from the M stage.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/data_mem_responder_if.sv | 27 ++
 rtl/trace_fifo.sv | 63 ++++++
 rtl/data_mem_responder.sv | 103 ++++++++++
 tb/tb_data_mem_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the data-memory responder: byte-enable encodings and the
// trace record layout.
package mem_pkg;

  localparam logic [3:0] BYTEEN_NONE    = 4'b0000;
  localparam logic [3:0] BYTEEN_WORD    = 4'b1111;
  localparam logic [3:0] BYTEEN_HALF_LO = 4'b0011;
  localparam logic [3:0] BYTEEN_HALF_HI = 4'b1100;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned TRACE_W     = 96;
  localparam int unsigned TR_DATA_LSB = 0;
  localparam int unsigned TR_ADDR_LSB = 32;
  localparam int unsigned TR_PC_LSB   = 64;

  // Byte-lane merge of store data into the existing word.
  function automatic logic [WORD_W-1:0] merge_lanes(input logic [WORD_W-1:0] old_w,
                                                    input logic [WORD_W-1:0] new_w,
                                                    input logic [3:0]        be);
    logic [WORD_W-1:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port plus the store-trace drain port.
interface data_mem_responder_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;
  logic        addr_err;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_overflow, addr_err
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_overflow, addr_err
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding committed-store trace records; reads 0 while empty.
module trace_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_c, do_pop_c;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = empty_o ? '0 : store_q[rd_ptr_q];

  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign do_pop_c  = pop_i && !empty_o;
  assign do_push_c = push_i && (!full_o || do_pop_c);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c && !reset) store_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: combinational word read, byte-lane merged write at the
// clock edge, and a trace FIFO recording every committed store.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(TRACE_DEPTH) + 1;

  logic [WORD_W-1:0]  mem_q [DEPTH_WORDS];
  logic [32:0]        offset_c;
  logic [31:0]        word_idx_c;
  logic [IDX_W-1:0]   idx_c;
  logic               in_range_c;
  logic               access_c;
  logic               wr_en_c;
  logic [WORD_W-1:0]  old_word_c;
  logic [WORD_W-1:0]  merged_c;
  logic [TRACE_W-1:0] rec_c;
  logic [TRACE_W-1:0] head_c;
  logic [CNT_W-1:0]   count_c;
  logic               full_c, empty_c, pop_c;
  logic               overflow_q, overflow_d;
  logic               addr_err_q, addr_err_d;

  // Borrow out of the 33-bit subtract flags addresses below the base.
  assign offset_c   = {1'b0, bus.m_data_addr} - {1'b0, BASE_ADDR};
  assign word_idx_c = {2'b00, offset_c[31:2]};
  assign in_range_c = !offset_c[32] && (word_idx_c < 32'(DEPTH_WORDS));
  assign idx_c      = word_idx_c[IDX_W-1:0];

  assign old_word_c = in_range_c ? mem_q[idx_c] : '0;
  assign merged_c   = merge_lanes(old_word_c, bus.m_data_wdata, bus.m_data_byteen);
  assign access_c   = !reset && (bus.m_data_byteen != BYTEEN_NONE);
  assign wr_en_c    = access_c && in_range_c;

  assign bus.m_data_rdata = old_word_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en_c) begin
      mem_q[idx_c] <= merged_c;
    end
  end

  always_comb begin
    rec_c = '0;
    rec_c[TR_PC_LSB   +: 32] = bus.m_inst_addr;
    rec_c[TR_ADDR_LSB +: 32] = {bus.m_data_addr[31:2], 2'b00};
    rec_c[TR_DATA_LSB +: 32] = merged_c;
  end

  assign pop_c = !empty_c && bus.trace_ready;

  trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_en_c),
    .din_i   (rec_c),
    .pop_i   (pop_c),
    .dout_o  (head_c),
    .count_o (count_c),
    .full_o  (full_c),
    .empty_o (empty_c)
  );

  // Sticky error flags: dropped trace entry, out-of-range access.
  always_comb begin
    overflow_d = overflow_q;
    addr_err_d = addr_err_q;
    if (wr_en_c && full_c && !pop_c) overflow_d = 1'b1;
    if (access_c && !in_range_c)     addr_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.trace_valid    = (count_c != '0);
  assign bus.trace_pc       = head_c[TR_PC_LSB   +: 32];
  assign bus.trace_addr     = head_c[TR_ADDR_LSB +: 32];
  assign bus.trace_data     = head_c[TR_DATA_LSB +: 32];
  assign bus.trace_overflow = overflow_q;
  assign bus.addr_err       = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: reads, merged stores, trace FIFO
// full/overflow behaviour, out-of-range access and reset mid-drain.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH_WORDS (3072),
    .BASE_ADDR   (32'h0),
    .TRACE_DEPTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                       input logic [31:0] pc, input logic rdy);
    bus.m_data_addr   = a;
    bus.m_data_wdata  = w;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    bus.trace_ready   = rdy;
  endtask

  // Pop exactly one head entry; returns settled one cycle later.
  task automatic pop_one();
    next_cyc();
    bus.trace_ready = 1'b1;
    next_cyc();
    bus.trace_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h0, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    next_cyc();
    next_cyc();
    reset = 1'b0;
    #1;
    checks++; if (bus.m_data_rdata !== 32'h0) begin errors++; $display("FAIL reset_rd0: got %h want %h", bus.m_data_rdata, 32'h0); end
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.trace_valid); end
    checks++; if (bus.trace_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.trace_overflow); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.addr_err); end
    checks++; if ({bus.trace_pc, bus.trace_addr, bus.trace_data} !== 96'h0) begin errors++; $display("FAIL reset_head: got %h want 0", {bus.trace_pc, bus.trace_addr, bus.trace_data}); end
    bus.m_data_addr = 32'h2FFC;
    #1;
    checks++; if (bus.m_data_rdata !== 32'h0) begin errors++; $display("FAIL reset_rd_last: got %h want %h", bus.m_data_rdata, 32'h0); end
  endtask

  task automatic test_store_word();
    next_cyc();
    drive(32'h10, 32'h12345678, BYTEEN_WORD, 32'h3000, 1'b0);
    #1;
    checks++; if (bus.m_data_rdata !== 32'h0) begin errors++; $display("FAIL sw_old: got %h want %h", bus.m_data_rdata, 32'h0); end
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL sw_nobypass: got %b want 0", bus.trace_valid); end
    next_cyc();
    drive(32'h10, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    #1;
    checks++; if (bus.m_data_rdata !== 32'h12345678) begin errors++; $display("FAIL sw_rd: got %h want %h", bus.m_data_rdata, 32'h12345678); end
    checks++; if (bus.trace_valid !== 1'b1) begin errors++; $display("FAIL sw_valid: got %b want 1", bus.trace_valid); end
    checks++; if (bus.trace_pc !== 32'h3000) begin errors++; $display("FAIL sw_pc: got %h want %h", bus.trace_pc, 32'h3000); end
    checks++; if (bus.trace_addr !== 32'h10) begin errors++; $display("FAIL sw_addr: got %h want %h", bus.trace_addr, 32'h10); end
    checks++; if (bus.trace_data !== 32'h12345678) begin errors++; $display("FAIL sw_data: got %h want %h", bus.trace_data, 32'h12345678); end
    pop_one();
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL sw_popped: got %b want 0", bus.trace_valid); end
  endtask

  task automatic test_store_byte();
    next_cyc();
    drive(32'h11, 32'h0000AB00, 4'b0010, 32'h3004, 1'b0);
    next_cyc();
    drive(32'h10, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    #1;
    checks++; if (bus.m_data_rdata !== 32'h1234AB78) begin errors++; $display("FAIL sb_rd: got %h want %h", bus.m_data_rdata, 32'h1234AB78); end
    checks++; if (bus.trace_addr !== 32'h10) begin errors++; $display("FAIL sb_addr: got %h want %h", bus.trace_addr, 32'h10); end
    checks++; if (bus.trace_data !== 32'h1234AB78) begin errors++; $display("FAIL sb_data: got %h want %h", bus.trace_data, 32'h1234AB78); end
    checks++; if (bus.trace_pc !== 32'h3004) begin errors++; $display("FAIL sb_pc: got %h want %h", bus.trace_pc, 32'h3004); end
    pop_one();
  endtask

  task automatic test_same_cycle();
    next_cyc();
    drive(32'h20, 32'hDEADBEEF, BYTEEN_WORD, 32'h3008, 1'b0);
    #1;
    checks++; if (bus.m_data_rdata !== 32'h0) begin errors++; $display("FAIL rw_old: got %h want %h", bus.m_data_rdata, 32'h0); end
    next_cyc();
    drive(32'h20, 32'h12340000, BYTEEN_HALF_HI, 32'h300C, 1'b0);
    #1;
    checks++; if (bus.m_data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_new: got %h want %h", bus.m_data_rdata, 32'hDEADBEEF); end
    next_cyc();
    drive(32'h22, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    #1;
    checks++; if (bus.m_data_rdata !== 32'h1234BEEF) begin errors++; $display("FAIL sh_hi: got %h want %h", bus.m_data_rdata, 32'h1234BEEF); end
    checks++; if (bus.trace_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_head0: got %h want %h", bus.trace_data, 32'hDEADBEEF); end
    pop_one();
    checks++; if (bus.trace_data !== 32'h1234BEEF) begin errors++; $display("FAIL rw_head1: got %h want %h", bus.trace_data, 32'h1234BEEF); end
    checks++; if (bus.trace_pc !== 32'h300C) begin errors++; $display("FAIL rw_pc1: got %h want %h", bus.trace_pc, 32'h300C); end
    pop_one();
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL rw_empty: got %b want 0", bus.trace_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pc, exp_addr, exp_data;
    for (int i = 0; i < 9; i++) begin
      next_cyc();
      drive(32'h100 + 32'(4*i), 32'hA0000000 + 32'(i), BYTEEN_WORD, 32'h4000 + 32'(4*i), 1'b0);
      #1;
      if (i == 8) begin
        checks++; if (bus.trace_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", bus.trace_overflow); end
      end
    end
    next_cyc();
    drive(32'h120, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    #1;
    checks++; if (bus.trace_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.trace_overflow); end
    checks++; if (bus.m_data_rdata !== 32'hA0000008) begin errors++; $display("FAIL ovf_arr: got %h want %h", bus.m_data_rdata, 32'hA0000008); end
    checks++; if (bus.trace_pc !== 32'h4000) begin errors++; $display("FAIL ovf_head: got %h want %h", bus.trace_pc, 32'h4000); end
    // Store and pop on the same cycle while full.
    next_cyc();
    drive(32'h140, 32'hA0000009, BYTEEN_WORD, 32'h4024, 1'b1);
    next_cyc();
    drive(32'h0, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    #1;
    checks++; if (bus.trace_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.trace_overflow); end
    for (int k = 0; k < 8; k++) begin
      exp_pc   = (k < 7) ? 32'h4004 + 32'(4*k) : 32'h4024;
      exp_addr = (k < 7) ? 32'h104 + 32'(4*k) : 32'h140;
      exp_data = (k < 7) ? 32'hA0000001 + 32'(k) : 32'hA0000009;
      checks++; if (bus.trace_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", k, bus.trace_valid); end
      checks++; if ({bus.trace_pc, bus.trace_addr, bus.trace_data} !== {exp_pc, exp_addr, exp_data}) begin
        errors++; $display("FAIL drain_entry[%0d]: got %h %h %h want %h %h %h", k, bus.trace_pc, bus.trace_addr, bus.trace_data, exp_pc, exp_addr, exp_data);
      end
      pop_one();
    end
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", bus.trace_valid); end
  endtask

  task automatic test_addr_err();
    next_cyc();
    drive(32'h2FFC, 32'h0BADF00D, BYTEEN_WORD, 32'h5000, 1'b0);
    next_cyc();
    drive(32'h3000, 32'h55555555, BYTEEN_WORD, 32'h5004, 1'b0);
    #1;
    checks++; if (bus.m_data_rdata !== 32'h0) begin errors++; $display("FAIL oob_rd: got %h want %h", bus.m_data_rdata, 32'h0); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", bus.addr_err); end
    next_cyc();
    drive(32'h2FFC, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    #1;
    checks++; if (bus.addr_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", bus.addr_err); end
    checks++; if (bus.m_data_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL last_word: got %h want %h", bus.m_data_rdata, 32'h0BADF00D); end
    checks++; if (bus.trace_pc !== 32'h5000) begin errors++; $display("FAIL err_head: got %h want %h", bus.trace_pc, 32'h5000); end
    pop_one();
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL err_nopush: got %b want 0", bus.trace_valid); end
    bus.m_data_addr = 32'h3000;
    #1;
    checks++; if (bus.m_data_rdata !== 32'h0) begin errors++; $display("FAIL oob_after: got %h want %h", bus.m_data_rdata, 32'h0); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      drive(32'h10 + 32'(4*i), 32'h11111111 * 32'(i+1), BYTEEN_WORD, 32'h6000 + 32'(4*i), 1'b0);
    end
    next_cyc();
    drive(32'h10, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    #1;
    checks++; if (bus.trace_valid !== 1'b1) begin errors++; $display("FAIL mid_queued: got %b want 1", bus.trace_valid); end
    next_cyc();
    reset = 1'b1;
    drive(32'h40, 32'h00000077, BYTEEN_WORD, 32'h6010, 1'b0);
    next_cyc();
    reset = 1'b0;
    drive(32'h10, 32'h0, BYTEEN_NONE, 32'h0, 1'b0);
    #1;
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", bus.trace_valid); end
    checks++; if (bus.trace_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b want 0", bus.trace_overflow); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", bus.addr_err); end
    checks++; if (bus.m_data_rdata !== 32'h0) begin errors++; $display("FAIL mid_word: got %h want %h", bus.m_data_rdata, 32'h0); end
    checks++; if (bus.trace_data !== 32'h0) begin errors++; $display("FAIL mid_head: got %h want %h", bus.trace_data, 32'h0); end
    bus.m_data_addr = 32'h40;
    #1;
    checks++; if (bus.m_data_rdata !== 32'h0) begin errors++; $display("FAIL rst_write: got %h want %h", bus.m_data_rdata, 32'h0); end
    next_cyc();
    #1;
    checks++; if (bus.trace_valid !== 1'b0) begin errors++; $display("FAIL rst_notrace: got %b want 0", bus.trace_valid); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_same_cycle();
    test_overflow();
    test_addr_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
